pin_entry_keypad: RTL and testbench

- Keypad front-end for the parking entry controller.
- Collects up to three decimal digits from the entry keypad and converts them to an 8-bit binary PIN.
- Presents the PIN on `psswrd_atmpt` with a one-cycle `try_psswrd` strobe, i.e. it drives the controller's PIN-attempt interface.
- Monitors `alarm_1` from the controller and locks the keypad out for a fixed time after repeated wrong PINs.

---
 rtl/pin_entry_keypad.sv | 115 +++++++++++
 tb/tb_pin_entry_keypad.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pin_entry_keypad.sv
// pin_entry_keypad: collects up to three decimal keypad digits into an 8-bit PIN and locks out after alarm_1.
// Optional inactivity timeout for partial entries is enabled by defining PIN_TIMEOUT_EN.
module pin_entry_keypad #(
    parameter int LOCK_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       alarm_1,
    output logic [7:0] psswrd_atmpt,
    output logic       try_psswrd,
    output logic [1:0] digit_count,
    output logic       entry_err,
    output logic       locked
);
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] COLLECT = 2'b01;
    localparam logic [1:0] LOCKOUT = 2'b10;
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    logic [1:0]    state;
    logic [9:0]    acc;
    logic          kv_r, al_r, al_p;
    logic [3:0]    kc_r;
    logic [LW-1:0] lock_cnt;
    logic          digit, clr, ent, lock_done;

    // Keys and alarm pass through one input register, so every event takes effect one edge after it is sampled
    assign digit     = kv_r && (kc_r <= 4'd9);
    assign clr       = kv_r && (kc_r == 4'hA);
    assign ent       = kv_r && (kc_r == 4'hB);
    assign lock_done = lock_cnt == LW'(LOCK_CYCLES - 1);
    assign locked    = state[1];

`ifdef PIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          act, to_exp;
    assign act    = ent || clr || (digit && digit_count != 2'd3);
    assign to_exp = (state == COLLECT) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            digit_count  <= '0;
            kv_r         <= 1'b0;
            kc_r         <= '0;
            al_r         <= 1'b0;
            al_p         <= 1'b0;
            lock_cnt     <= '0;
            psswrd_atmpt <= '0;
            try_psswrd   <= 1'b0;
            entry_err    <= 1'b0;
`ifdef PIN_TIMEOUT_EN
            to_cnt       <= '0;
`endif
        end else begin
            kv_r       <= key_valid;
            kc_r       <= key_code;
            al_r       <= alarm_1;
            al_p       <= al_r;
            try_psswrd <= 1'b0;
            entry_err  <= 1'b0;
`ifdef PIN_TIMEOUT_EN
            to_cnt     <= (state == COLLECT && !act) ? to_cnt + 1'b1 : '0;
`endif
            if (state == LOCKOUT) begin
                lock_cnt <= lock_cnt + 1'b1;
                if (lock_done) state <= IDLE;
            end else if (al_r && !al_p) begin
                state       <= LOCKOUT;
                acc         <= '0;
                digit_count <= '0;
                lock_cnt    <= '0;
            end else if (ent) begin
                entry_err <= (digit_count == 2'd0) || (acc > 10'd255);
                if (digit_count != 2'd0) begin
                    if (acc <= 10'd255) begin
                        psswrd_atmpt <= acc[7:0];
                        try_psswrd   <= 1'b1;
                    end
                    state       <= IDLE;
                    acc         <= '0;
                    digit_count <= '0;
                end
            end else if (clr) begin
                state       <= IDLE;
                acc         <= '0;
                digit_count <= '0;
            end else if (digit && digit_count != 2'd3) begin
                acc         <= acc * 10'd10 + {6'd0, kc_r};
                digit_count <= digit_count + 1'b1;
                state       <= COLLECT;
            end
`ifdef PIN_TIMEOUT_EN
            else if (to_exp) begin
                entry_err   <= 1'b1;
                state       <= IDLE;
                acc         <= '0;
                digit_count <= '0;
            end
`endif
            else if (digit) begin
                entry_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pin_entry_keypad.sv
// tb_pin_entry_keypad: table-driven checks of pin_entry_keypad plus hand-written lockout, timeout and reset sequences.
module tb_pin_entry_keypad;
    logic       clk = 1'b0, rst = 1'b1, key_valid = 1'b0, alarm_1 = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [7:0] psswrd_atmpt;
    logic       try_psswrd, entry_err, locked;
    logic [1:0] digit_count;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    pin_entry_keypad #(.LOCK_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .alarm_1(alarm_1),
        .psswrd_atmpt(psswrd_atmpt), .try_psswrd(try_psswrd), .digit_count(digit_count),
        .entry_err(entry_err), .locked(locked)
    );

    typedef struct {
        logic       kv;
        logic [3:0] code;
        logic       t;
        logic       e;
        logic [7:0] pin;
        logic [1:0] cnt;
    } vec_t;
    vec_t v[35];

    task automatic chk(input string n, input int i, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h", n, i, a, e);
        end
    endtask

    task automatic drive(input logic kv, input logic [3:0] c);
        key_valid = kv;
        key_code  = c;
    endtask

    task automatic sv(input int i, input logic kv, input logic [3:0] c, input logic t, input logic e,
                      input logic [7:0] p, input logic [1:0] n);
        v[i] = '{kv, c, t, e, p, n};
    endtask

    // Each row: inputs driven this cycle, outputs expected this cycle (effect of inputs two rows earlier)
    initial begin
        sv(0, 0, 4'h0, 0, 0, 8'h00, 0);  sv(1, 0, 4'h0, 0, 0, 8'h00, 0);
        sv(2, 1, 4'h8, 0, 0, 8'h00, 0);  sv(3, 1, 4'h7, 0, 0, 8'h00, 0);
        sv(4, 1, 4'hB, 0, 0, 8'h00, 1);  sv(5, 0, 4'h0, 0, 0, 8'h00, 2);
        sv(6, 0, 4'h0, 1, 0, 8'h57, 0);  sv(7, 0, 4'h0, 0, 0, 8'h57, 0);
        sv(8, 1, 4'h2, 0, 0, 8'h57, 0);  sv(9, 1, 4'h5, 0, 0, 8'h57, 0);
        sv(10, 1, 4'h6, 0, 0, 8'h57, 1); sv(11, 1, 4'hB, 0, 0, 8'h57, 2);
        sv(12, 0, 4'h0, 0, 0, 8'h57, 3); sv(13, 0, 4'h0, 0, 1, 8'h57, 0);
        sv(14, 0, 4'h0, 0, 0, 8'h57, 0); sv(15, 1, 4'h1, 0, 0, 8'h57, 0);
        sv(16, 1, 4'h2, 0, 0, 8'h57, 0); sv(17, 1, 4'h3, 0, 0, 8'h57, 1);
        sv(18, 1, 4'h4, 0, 0, 8'h57, 2); sv(19, 1, 4'hB, 0, 0, 8'h57, 3);
        sv(20, 0, 4'h0, 0, 1, 8'h57, 3); sv(21, 0, 4'h0, 1, 0, 8'h7B, 0);
        sv(22, 0, 4'h0, 0, 0, 8'h7B, 0); sv(23, 1, 4'h4, 0, 0, 8'h7B, 0);
        sv(24, 1, 4'hA, 0, 0, 8'h7B, 0); sv(25, 1, 4'hB, 0, 0, 8'h7B, 1);
        sv(26, 0, 4'h0, 0, 0, 8'h7B, 0); sv(27, 0, 4'h0, 0, 1, 8'h7B, 0);
        sv(28, 0, 4'h0, 0, 0, 8'h7B, 0); sv(29, 1, 4'h9, 0, 0, 8'h7B, 0);
        sv(30, 1, 4'hE, 0, 0, 8'h7B, 0); sv(31, 1, 4'hB, 0, 0, 8'h7B, 1);
        sv(32, 0, 4'h0, 0, 0, 8'h7B, 1); sv(33, 0, 4'h0, 1, 0, 8'h09, 0);
        sv(34, 0, 4'h0, 0, 0, 8'h09, 0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            drive(v[i].kv, v[i].code);
            chk("try", i, 32'(try_psswrd), 32'(v[i].t));
            chk("err", i, 32'(entry_err), 32'(v[i].e));
            chk("pin", i, 32'(psswrd_atmpt), 32'(v[i].pin));
            chk("cnt", i, 32'(digit_count), 32'(v[i].cnt));
            chk("locked", i, 32'(locked), 32'd0);
        end

        begin
            int lk, first, bad;
            lk = 0; first = -1; bad = 0;
            @(negedge clk);
            alarm_1 = 1'b1;
            drive(1, 4'h5);
            for (int j = 0; j < 14; j++) begin
                @(negedge clk);
                if (j < 2) drive(1, j == 0 ? 4'h9 : 4'hB);
                else drive(0, 4'h0);
                if (locked) begin
                    lk++;
                    if (first < 0) first = j;
                end
                if (try_psswrd || entry_err || digit_count != 2'd0) bad++;
            end
            chk("lock_len", 0, 32'(lk), 32'd4);
            chk("lock_start", 0, 32'(first), 32'd1);
            chk("lock_quiet", 0, 32'(bad), 32'd0);
        end

        @(negedge clk); drive(1, 4'h8);
        @(negedge clk); drive(1, 4'h7);
        @(negedge clk); drive(1, 4'hB);
        @(negedge clk); drive(0, 4'h0);
        @(negedge clk);
        chk("post_lock_try", 0, 32'(try_psswrd), 32'd1);
        chk("post_lock_pin", 0, 32'(psswrd_atmpt), 32'h57);
        chk("post_lock_locked", 0, 32'(locked), 32'd0);

        begin
            int first;
            first = -1;
            @(negedge clk); drive(1, 4'h3);
            for (int j = 1; j <= 30; j++) begin
                @(negedge clk);
                drive(0, 4'h0);
                if (entry_err && first < 0) first = j;
            end
`ifdef PIN_TIMEOUT_EN
            chk("timeout_at", 0, 32'(first), 32'd12);
            chk("timeout_cnt", 0, 32'(digit_count), 32'd0);
`else
            chk("no_timeout", 0, 32'(first), 32'hFFFF_FFFF);
            chk("entry_kept", 0, 32'(digit_count), 32'd1);
`endif
            @(negedge clk); drive(1, 4'hA);
            @(negedge clk); drive(0, 4'h0);
            @(negedge clk);
        end

        begin
            int pulses;
            pulses = 0;
            @(negedge clk); drive(1, 4'h1);
            @(negedge clk); drive(1, 4'h2);
            @(negedge clk); drive(1, 4'hB);
            @(negedge clk); drive(0, 4'h0); rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("rst_pin", 0, 32'(psswrd_atmpt), 32'h00);
            chk("rst_cnt", 0, 32'(digit_count), 32'd0);
            chk("rst_try", 0, 32'(try_psswrd), 32'd0);
            chk("rst_err", 0, 32'(entry_err), 32'd0);
            chk("rst_locked", 0, 32'(locked), 32'd0);
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                if (try_psswrd || entry_err) pulses++;
            end
            chk("rst_no_pulse", 0, 32'(pulses), 32'd0);
            chk("rst_pin_hold", 0, 32'(psswrd_atmpt), 32'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
